// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared constants, arbiter state type and index helpers for the mesh router
package noc_pkg;

    // Input port indices of a router
    localparam int PORT_N  = 0;
    localparam int PORT_S  = 1;
    localparam int PORT_W  = 2;
    localparam int PORT_E  = 3;
    localparam int PORT_PE = 4;

    localparam int NOC_NUM_IN = 5;
    localparam int NOC_NUM_VC = 4;
    localparam int NOC_VC_W   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Next port index after idx, wrapping at n
    function automatic int next_port(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // Bit vector with only bit idx set (idx below 32)
    function automatic logic [31:0] onehot32(input int idx);
        logic [31:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or after ptr
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    // Scan the requests cyclically starting at ptr; the first hit wins
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] pos;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                idx      = pos;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// rtl/noc_out_port_arbiter.sv - output-port switch/VC allocator, wormhole + round-robin (optional watchdog: NOC_ARB_WATCHDOG_EN)
module noc_out_port_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN  = NOC_NUM_IN,
    parameter int NUM_VC  = NOC_NUM_VC,
    parameter int VC_W    = NOC_VC_W
`ifdef NOC_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req_i,
    input  logic [NUM_IN-1:0] req_head_i,
    input  logic [NUM_IN-1:0] req_tail_i,
    input  logic [NUM_VC-1:0] on_off_i,
    input  logic [NUM_VC-1:0] vc_reserved_i,
    output logic [NUM_IN-1:0] gnt_o,
    output logic [VC_W-1:0]   out_vc_o,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic [NUM_VC-1:0] vc_hold_o,
    output logic              wdog_err_o
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner;
    logic [VC_W-1:0]   out_vc;

    logic [NUM_IN-1:0] cand;
    logic [NUM_IN-1:0] cand_gnt;
    logic [IDX_W-1:0]  cand_idx;
    logic [NUM_VC-1:0] vc_free;
    logic              vc_any;
    logic [VC_W-1:0]   vc_pick;
    logic              locked;
    logic              xfer;
    logic              tail_xfer;
    logic [IDX_W-1:0]  owner_next;

    // Only head flits may open a packet; a VC must be unheld and ON to be allocated
    assign cand    = req_i & req_head_i;
    assign vc_free = ~vc_reserved_i & on_off_i;

    rr_arbiter #(
        .N     (NUM_IN),
        .IDX_W (IDX_W)
    ) u_in_sel (
        .req (cand),
        .ptr (rr_ptr),
        .gnt (cand_gnt),
        .idx (cand_idx)
    );

    // Lowest-index free downstream VC
    always_comb begin
        vc_any  = 1'b0;
        vc_pick = '0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (vc_free[v]) begin
                vc_any  = 1'b1;
                vc_pick = VC_W'(v);
            end
        end
    end

    assign locked     = (state == LOCKED);
    assign xfer       = locked && req_i[owner] && on_off_i[out_vc];
    assign tail_xfer  = xfer && req_tail_i[owner];
    assign owner_next = IDX_W'(next_port(int'(owner), NUM_IN));

    // Grant goes only to the owner, gated by the owned VC's ON/OFF bit
    always_comb begin
        gnt_o = '0;
        if (xfer) begin
            gnt_o[owner] = 1'b1;
        end
    end

    // Advertise the held VC downstream while a packet is in flight
    always_comb begin
        vc_hold_o = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_hold_o[v] = locked && (out_vc == VC_W'(v));
        end
    end

    assign out_valid_o = |gnt_o;
    assign busy_o      = locked;
    assign out_vc_o    = out_vc;

`ifdef NOC_ARB_WATCHDOG_EN
    logic [7:0] stall_cnt;
    logic       wdog_err;
    assign wdog_err_o = wdog_err;
`else
    assign wdog_err_o = 1'b0;
`endif

    // Arbitration FSM: IDLE allocates input and VC, LOCKED streams until the tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            out_vc <= '0;
`ifdef NOC_ARB_WATCHDOG_EN
            stall_cnt <= '0;
            wdog_err  <= 1'b0;
`endif
        end else begin
`ifdef NOC_ARB_WATCHDOG_EN
            wdog_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef NOC_ARB_WATCHDOG_EN
                    stall_cnt <= '0;
`endif
                    if ((|cand_gnt) && vc_any) begin
                        owner  <= cand_idx;
                        out_vc <= vc_pick;
                        state  <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (tail_xfer) begin
                        state  <= IDLE;
                        rr_ptr <= owner_next;
`ifdef NOC_ARB_WATCHDOG_EN
                        stall_cnt <= '0;
                    end else if (xfer) begin
                        stall_cnt <= '0;
                    end else if (int'(stall_cnt) >= TIMEOUT - 1) begin
                        // Owner stalled too long: drop it and let the others in
                        state     <= IDLE;
                        rr_ptr    <= owner_next;
                        stall_cnt <= '0;
                        wdog_err  <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// tb/tb_noc_out_port_arbiter.sv - table-driven self-checking bench for noc_out_port_arbiter
module tb_noc_out_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0, hd = '0, tl = '0;
    logic [3:0] on = 4'b1111, rsv = '0;
    logic [4:0] gnt;
    logic [1:0] out_vc;
    logic       out_valid, busy, wdog_err;
    logic [3:0] vc_hold;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [4:0] req, hd, tl;
        logic [3:0] on, rsv;
        logic [4:0] g;
        logic [1:0] vc;
        logic       busy;
        logic [3:0] hold;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    noc_out_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .req_head_i    (hd),
        .req_tail_i    (tl),
        .on_off_i      (on),
        .vc_reserved_i (rsv),
        .gnt_o         (gnt),
        .out_vc_o      (out_vc),
        .out_valid_o   (out_valid),
        .busy_o        (busy),
        .vc_hold_o     (vc_hold),
        .wdog_err_o    (wdog_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [4:0] rq, input logic [4:0] h, input logic [4:0] t,
                       input logic [3:0] o, input logic [3:0] rs, input logic [4:0] g,
                       input logic [1:0] vc, input logic b, input logic [3:0] hl);
        vec_t v;
        v.rst = r; v.req = rq; v.hd = h; v.tl = t; v.on = o; v.rsv = rs;
        v.g = g; v.vc = vc; v.busy = b; v.hold = hl;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        //   rst  req       head      tail      on_off   resv     gnt       vc     busy  hold
        // reset
        add(1, 5'b00000, 5'b00000, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        // single-flit packet on input 0
        add(0, 5'b00001, 5'b00001, 5'b00001, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b00001, 5'b00001, 5'b00001, 4'b1111, 4'b0000, 5'b00001, 2'd0, 1, 4'b0001);
        add(0, 5'b00000, 5'b00000, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        // VC selection with VCs 0,1 reserved
        add(0, 5'b00100, 5'b00100, 5'b00100, 4'b1111, 4'b0011, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b00100, 5'b00100, 5'b00100, 4'b1111, 4'b0011, 5'b00100, 2'd2, 1, 4'b0100);
        add(0, 5'b00000, 5'b00000, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd2, 0, 4'b0000);
        // reset pointer, then inputs 0 and 3 send 3-flit packets back to back
        add(1, 5'b00000, 5'b00000, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b01001, 5'b01001, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b01001, 5'b01001, 5'b00000, 4'b1111, 4'b0000, 5'b00001, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b01000, 5'b00000, 4'b1111, 4'b0000, 5'b00001, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b01000, 5'b00001, 4'b1111, 4'b0000, 5'b00001, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b01001, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b01001, 5'b01001, 5'b00000, 4'b1111, 4'b0000, 5'b01000, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b00001, 5'b00000, 4'b1111, 4'b0000, 5'b01000, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b00001, 5'b01000, 4'b1111, 4'b0000, 5'b01000, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b01001, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b01001, 5'b01001, 5'b00000, 4'b1111, 4'b0000, 5'b00001, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b01000, 5'b00000, 4'b1111, 4'b0000, 5'b00001, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b01000, 5'b00001, 4'b1111, 4'b0000, 5'b00001, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b01001, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b01001, 5'b01001, 5'b00000, 4'b1111, 4'b0000, 5'b01000, 2'd0, 1, 4'b0001);
        // VC0 OFF for 4 cycles mid-packet, reservations toggled while locked
        add(0, 5'b01001, 5'b00001, 5'b00000, 4'b1110, 4'b0000, 5'b00000, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b00001, 5'b00000, 4'b1110, 4'b1111, 5'b00000, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b00001, 5'b00000, 4'b1110, 4'b1111, 5'b00000, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b00001, 5'b00000, 4'b1110, 4'b1111, 5'b00000, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b00001, 5'b00000, 4'b1111, 4'b1111, 5'b01000, 2'd0, 1, 4'b0001);
        add(0, 5'b01001, 5'b00001, 5'b01000, 4'b1111, 4'b0000, 5'b01000, 2'd0, 1, 4'b0001);
        add(0, 5'b00000, 5'b00000, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        // orphan body/tail flit is ignored
        add(0, 5'b00010, 5'b00000, 5'b00010, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b00010, 5'b00000, 5'b00010, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        // no free VC: head waits; VC3 freed -> allocated
        add(0, 5'b00010, 5'b00010, 5'b00010, 4'b1111, 4'b1111, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b00010, 5'b00010, 5'b00010, 4'b1111, 4'b1111, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b00010, 5'b00010, 5'b00000, 4'b1111, 4'b0111, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b00010, 5'b00010, 5'b00000, 4'b1111, 4'b0111, 5'b00010, 2'd3, 1, 4'b1000);
        // owner drops req while input 2 heads in: lock held, no preemption
        add(0, 5'b00100, 5'b00100, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd3, 1, 4'b1000);
        add(0, 5'b00110, 5'b00100, 5'b00010, 4'b1111, 4'b0000, 5'b00010, 2'd3, 1, 4'b1000);
        add(0, 5'b00100, 5'b00100, 5'b00100, 4'b1111, 4'b0000, 5'b00000, 2'd3, 0, 4'b0000);
        add(0, 5'b00100, 5'b00100, 5'b00100, 4'b1111, 4'b0000, 5'b00100, 2'd0, 1, 4'b0001);
        add(0, 5'b00000, 5'b00000, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        // reset during the second flit, then a head on input 4
        add(0, 5'b00001, 5'b00001, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b00001, 5'b00001, 5'b00000, 4'b1111, 4'b0000, 5'b00001, 2'd0, 1, 4'b0001);
        add(1, 5'b00001, 5'b00000, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b10000, 5'b10000, 5'b10000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);
        add(0, 5'b10000, 5'b10000, 5'b10000, 4'b1111, 4'b0000, 5'b10000, 2'd0, 1, 4'b0001);
        add(0, 5'b00000, 5'b00000, 5'b00000, 4'b1111, 4'b0000, 5'b00000, 2'd0, 0, 4'b0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; req = vecs[i].req; hd = vecs[i].hd; tl = vecs[i].tl;
            on = vecs[i].on; rsv = vecs[i].rsv;
            #1;
            check($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].g));
            check($sformatf("row%0d out_vc", i), 32'(out_vc), 32'(vecs[i].vc));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("row%0d vc_hold", i), 32'(vc_hold), 32'(vecs[i].hold));
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(|vecs[i].g));
            check($sformatf("row%0d wdog_err", i), 32'(wdog_err), 32'd0);
        end

        // 4-flit packet on input 1: one idle cycle, then a flit every cycle
        @(negedge clk);
        rst = 0; req = 5'b00010; hd = 5'b00010; tl = '0; on = 4'b1111; rsv = '0;
        #1;
        check("burst head latency", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hd = (k == 0) ? 5'b00010 : 5'b00000;
            tl = (k == 3) ? 5'b00010 : 5'b00000;
            #1;
            check($sformatf("burst flit%0d gnt", k), 32'(gnt), 32'h02);
        end
        @(negedge clk);
        req = '0; hd = '0; tl = '0;
        #1;
        check("burst released", 32'(busy), 32'd0);

        // Reset asserted between edges clears outputs at once
        @(negedge clk);
        req = 5'b00100; hd = 5'b00100; tl = '0;
        @(negedge clk);
        #1;
        check("async pre gnt", 32'(gnt), 32'h04);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check("async gnt", 32'(gnt), 32'd0);
        check("async busy", 32'(busy), 32'd0);
        check("async vc_hold", 32'(vc_hold), 32'd0);
        @(negedge clk);
        rst = 0; req = 5'b01000; hd = 5'b01000; tl = 5'b01000;
        #1;
        check("post reset idle", 32'(busy), 32'd0);
        n = 0;
        while (!out_valid && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("post reset grant", 32'(gnt), 32'h08);
        check("post reset latency", 32'(n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
